// File: rtl/mips_pkg.sv
// Shared types and constants for the interrupt controller slice.
// FSM encoding, reset mask level and default source count.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SVC
  } state_e;

  localparam int   NUM_IRQ_DEF = 8;
  localparam logic MASK_RST    = 1'b1;

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-wins priority encoder.
// Produces the index of the highest-priority set request plus a valid flag.
module prio_enc #(
  parameter int NUM_IRQ = 8,
  parameter int VEC_W   = 3
) (
  input  logic [NUM_IRQ-1:0] req_i,
  output logic [VEC_W-1:0]   idx_o,
  output logic               valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = VEC_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Latches, masks and prioritises IRQ/NMI edges and runs the
// INT/NMI -> INA handshake with the Controller until end-of-interrupt.
module interrupt_controller
  import mips_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEF,
  parameter int VEC_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               nmiIn,
  input  logic               maskWe,
  input  logic [NUM_IRQ-1:0] maskData,
  input  logic               INTD,
  input  logic               INA,
  input  logic               eoi,
  output logic               INT,
  output logic               NMI,
  output logic [VEC_W-1:0]   vector,
  output logic               isNmi,
  output logic               inService,
  output logic [NUM_IRQ-1:0] mask
);

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] irq_q;
  logic               nmi_in_q;
  logic               nmi_pend_q, nmi_pend_d;
  logic               nmi_act_q, nmi_act_d;
  logic               int_q, int_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic               isnmi_q, isnmi_d;

  logic [NUM_IRQ-1:0] elig;
  logic [NUM_IRQ-1:0] clr;
  logic [VEC_W-1:0]   win;
  logic               win_v;
  logic               nmi_rise;
  logic               nmi_act_e;
  logic               nmi_req_e;
  logic               nmi_ack;
  logic               svc_eoi;

  assign elig = pend_q & ~mask_q;

  prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .VEC_W   (VEC_W)
  ) u_prio (
    .req_i   (elig),
    .idx_o   (win),
    .valid_o (win_v)
  );

  // eoi is applied before INA is judged, so INA sees post-eoi NMI state
  assign nmi_rise  = nmiIn & ~nmi_in_q;
  assign nmi_act_e = nmi_act_q & ~eoi;
  assign nmi_req_e = nmi_pend_q & ~nmi_act_e;
  assign nmi_ack   = INA & nmi_req_e;
  assign svc_eoi   = eoi & ~nmi_act_q & (state_q == SVC);

  always_comb begin
    state_d = state_q;
    int_d   = int_q;
    vec_d   = vec_q;
    isnmi_d = isnmi_q;
    clr     = '0;
    if (nmi_ack) isnmi_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        int_d = 1'b0;
        if (win_v && !INTD && !nmi_act_q) begin
          state_d = REQ;
          int_d   = 1'b1;
        end
      end
      REQ: begin
        if (INTD || !win_v) begin
          state_d = IDLE;
          int_d   = 1'b0;
        end else if (INA && !nmi_req_e) begin
          vec_d      = win;
          clr[win]   = 1'b1;
          int_d      = 1'b0;
          isnmi_d    = 1'b0;
          state_d    = SVC;
        end
      end
      SVC: begin
        int_d = 1'b0;
        if (svc_eoi) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        int_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    pend_d     = (pend_q & ~clr) | (irq & ~irq_q);
    mask_d     = maskWe ? maskData : mask_q;
    nmi_pend_d = (nmi_pend_q & ~nmi_ack) | nmi_rise;
    nmi_act_d  = nmi_ack ? 1'b1 : nmi_act_e;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      mask_q     <= {NUM_IRQ{MASK_RST}};
      irq_q      <= irq;
      nmi_in_q   <= nmiIn;
      nmi_pend_q <= 1'b0;
      nmi_act_q  <= 1'b0;
      int_q      <= 1'b0;
      vec_q      <= '0;
      isnmi_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      irq_q      <= irq;
      nmi_in_q   <= nmiIn;
      nmi_pend_q <= nmi_pend_d;
      nmi_act_q  <= nmi_act_d;
      int_q      <= int_d;
      vec_q      <= vec_d;
      isnmi_q    <= isnmi_d;
    end
  end

  assign INT       = int_q;
  assign NMI       = nmi_pend_q & ~nmi_act_q;
  assign vector    = vec_q;
  assign isNmi     = isnmi_q;
  assign inService = (state_q == SVC) | nmi_act_q;
  assign mask      = mask_q;

endmodule
